// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined ripple adder.
package adder_pkg;

    localparam int unsigned ADDER_WIDTH = 16;
    localparam int unsigned ADDER_SEG_W = 4;

    // Number of pipeline segments for a given operand width and segment width.
    function automatic int unsigned nseg(input int unsigned width, input int unsigned seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/adder_segment.sv
// One pipeline segment: a ripple chain of NAND-built full-adder bit cells.
module adder_segment
    import adder_pkg::*;
#(
    parameter int unsigned SEG_W = ADDER_SEG_W
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b_eff,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic [SEG_W-1:0] p,
    output logic [SEG_W-1:0] g,
    output logic [SEG_W-1:0] c,
    output logic             cout
);

    logic carry;
    logic n_ab;
    logic n_a;
    logic n_b;
    logic n_pc;
    logic n_px;
    logic n_cx;

    // Ripple through the bit cells; each cell is a 9-NAND full adder.
    always_comb begin
        sum   = '0;
        p     = '0;
        g     = '0;
        c     = '0;
        carry = cin;
        n_ab  = 1'b1;
        n_a   = 1'b1;
        n_b   = 1'b1;
        n_pc  = 1'b1;
        n_px  = 1'b1;
        n_cx  = 1'b1;
        for (int unsigned i = 0; i < SEG_W; i++) begin
            n_ab   = ~(a[i] & b_eff[i]);
            n_a    = ~(a[i] & n_ab);
            n_b    = ~(b_eff[i] & n_ab);
            p[i]   = ~(n_a & n_b);
            g[i]   = ~n_ab;
            n_pc   = ~(p[i] & carry);
            n_px   = ~(p[i] & n_pc);
            n_cx   = ~(carry & n_pc);
            sum[i] = ~(n_px & n_cx);
            carry  = ~(n_ab & n_pc);
            c[i]   = carry;
        end
        cout = carry;
    end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Segmented ripple-carry add/sub with one register stage per segment and stall-all backpressure.
module pipelined_ripple_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH,
    parameter int unsigned SEG_W = ADDER_SEG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] p_out,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] c_out
);

    localparam int unsigned NSEG = nseg(WIDTH, SEG_W);

    // Per-stage payload: skewed operands ahead, deskewed results behind, inter-segment carry.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] c;
        logic             carry;
        logic             ovf;
    } stage_t;

    stage_t           src     [NSEG];
    stage_t           stage_d [NSEG];
    stage_t           stage_q [NSEG];
    logic [SEG_W-1:0] seg_a   [NSEG];
    logic [SEG_W-1:0] seg_b   [NSEG];
    logic [SEG_W-1:0] seg_s   [NSEG];
    logic [SEG_W-1:0] seg_p   [NSEG];
    logic [SEG_W-1:0] seg_g   [NSEG];
    logic [SEG_W-1:0] seg_c   [NSEG];
    logic             seg_ci  [NSEG];
    logic             seg_co  [NSEG];
    logic             adv;
    logic             msb_cin;

    // Whole pipe advances unless the output holds a beat nobody takes.
    assign adv      = !stage_q[NSEG-1].valid || out_ready;
    assign in_ready = adv;

    // Stage sources: fresh beat for segment 0, previous stage register otherwise.
    always_comb begin
        for (int unsigned k = 0; k < NSEG; k++) begin
            src[k] = '0;
        end
        src[0].valid = in_valid && adv;
        src[0].a     = a;
        src[0].b     = sub ? ~b : b;
        src[0].carry = sub ? 1'b1 : cin;
        for (int unsigned k = 1; k < NSEG; k++) begin
            src[k] = stage_q[k-1];
        end
        for (int unsigned k = 0; k < NSEG; k++) begin
            seg_a[k]  = src[k].a[k*SEG_W +: SEG_W];
            seg_b[k]  = src[k].b[k*SEG_W +: SEG_W];
            seg_ci[k] = src[k].carry;
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .a     (seg_a[k]),
            .b_eff (seg_b[k]),
            .cin   (seg_ci[k]),
            .sum   (seg_s[k]),
            .p     (seg_p[k]),
            .g     (seg_g[k]),
            .c     (seg_c[k]),
            .cout  (seg_co[k])
        );
    end

    // Carry into the MSB comes from inside the last segment.
    if (SEG_W == 1) begin : g_msb_single
        assign msb_cin = seg_ci[NSEG-1];
    end else begin : g_msb_chain
        assign msb_cin = seg_c[NSEG-1][SEG_W-2];
    end

    // Merge each segment's results into its stage payload; overflow set in the last stage.
    always_comb begin
        for (int unsigned k = 0; k < NSEG; k++) begin
            stage_d[k]                         = src[k];
            stage_d[k].sum[k*SEG_W +: SEG_W]   = seg_s[k];
            stage_d[k].p[k*SEG_W +: SEG_W]     = seg_p[k];
            stage_d[k].g[k*SEG_W +: SEG_W]     = seg_g[k];
            stage_d[k].c[k*SEG_W +: SEG_W]     = seg_c[k];
            stage_d[k].carry                   = seg_co[k];
        end
        stage_d[NSEG-1].ovf = seg_co[NSEG-1] ^ msb_cin;
    end

    // Stage registers: cleared on reset, held while the pipe is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NSEG; k++) begin
                stage_q[k] <= '0;
            end
        end else if (adv) begin
            for (int unsigned k = 0; k < NSEG; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[NSEG-1].valid;
    assign sum       = stage_q[NSEG-1].sum;
    assign cout      = stage_q[NSEG-1].carry;
    assign ovf       = stage_q[NSEG-1].ovf;
    assign p_out     = stage_q[NSEG-1].p;
    assign g_out     = stage_q[NSEG-1].g;
    assign c_out     = stage_q[NSEG-1].c;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench for pipelined_ripple_adder: directed vectors, backpressured stream, reset, parameter sweep.
module tb_pipelined_ripple_adder;

    typedef struct {
        logic [15:0] sum;
        logic [15:0] p;
        logic [15:0] g;
        logic [15:0] c;
        logic        cout;
        logic        ovf;
        int          acc;
        bit          chk_lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic [15:0] p_out;
    logic [15:0] g_out;
    logic [15:0] c_out;

    // Sweep instances share one stimulus bus.
    logic        sw_valid;
    logic [31:0] sw_a;
    logic [31:0] sw_b;
    logic        sw_cin;
    logic        sw_sub;
    logic        s0_ir, s0_ov, s0_co, s0_of;
    logic [7:0]  s0_sum, s0_p, s0_g, s0_c;
    logic        s1_ir, s1_ov, s1_co, s1_of;
    logic [7:0]  s1_sum, s1_p, s1_g, s1_c;
    logic        s2_ir, s2_ov, s2_co, s2_of;
    logic [31:0] s2_sum, s2_p, s2_g, s2_c;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t sv[$];
    bit   rand_rdy = 1'b0;
    bit   stall_prev = 1'b0;
    logic [18:0] held_res;
    logic [47:0] held_prb;

    pipelined_ripple_adder #(.WIDTH(16), .SEG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf),
        .p_out(p_out), .g_out(g_out), .c_out(c_out)
    );

    pipelined_ripple_adder #(.WIDTH(8), .SEG_W(8)) u_s0 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s0_ir),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub),
        .out_valid(s0_ov), .out_ready(1'b1),
        .sum(s0_sum), .cout(s0_co), .ovf(s0_of),
        .p_out(s0_p), .g_out(s0_g), .c_out(s0_c)
    );

    pipelined_ripple_adder #(.WIDTH(8), .SEG_W(2)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s1_ir),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub),
        .out_valid(s1_ov), .out_ready(1'b1),
        .sum(s1_sum), .cout(s1_co), .ovf(s1_of),
        .p_out(s1_p), .g_out(s1_g), .c_out(s1_c)
    );

    pipelined_ripple_adder #(.WIDTH(32), .SEG_W(4)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s2_ir),
        .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
        .out_valid(s2_ov), .out_ready(1'b1),
        .sum(s2_sum), .cout(s2_co), .ovf(s2_of),
        .p_out(s2_p), .g_out(s2_g), .c_out(s2_c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s, input logic co, input logic of,
                                input logic [15:0] pv, input logic [15:0] gv, input logic [15:0] cv,
                                input bit lat);
        exp_t e;
        e.sum = s; e.cout = co; e.ovf = of; e.p = pv; e.g = gv; e.c = cv;
        e.acc = 0; e.chk_lat = lat;
        return e;
    endfunction

    // Reference built from whole-word arithmetic, not from bit cells.
    function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                   input logic ci, input logic sb);
        exp_t        e;
        logic [15:0] be;
        logic        c0;
        logic [16:0] full;
        logic [16:0] part;
        logic [16:0] m;
        be = sb ? ~bv : bv;
        c0 = sb ? 1'b1 : ci;
        full = {1'b0, av} + {1'b0, be} + 17'(c0);
        e.sum = full[15:0];
        e.cout = full[16];
        e.p = av ^ be;
        e.g = av & be;
        e.c = '0;
        for (int i = 0; i < 16; i++) begin
            m = (17'd1 << (i + 1)) - 17'd1;
            part = ({1'b0, av} & m) + ({1'b0, be} & m) + 17'(c0);
            e.c[i] = part[i+1];
        end
        e.ovf = (av[15] == be[15]) && (e.sum[15] != av[15]);
        e.acc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    // Present one beat, wait (bounded) for acceptance, push its expectation.
    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic sb, input exp_t e_in);
        exp_t e;
        int   n;
        e = e_in;
        n = 0;
        in_valid = 1'b1; a = av; b = bv; cin = ci; sub = sb;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) break;
        end
        if (n > 200) begin
            check("accept_timeout", 64'(n), 64'd0);
        end else begin
            e.acc = cyc;
            @(posedge clk);
            sv.push_back(e);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sv.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sv.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Random backpressure on the main instance.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: handshake rule, stall stability, and in-order scoreboard pops.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (stall_prev) begin
                check("stall_hold_result", 64'({out_valid, sum, cout, ovf}), 64'(held_res));
                check("stall_hold_probes", 64'({p_out, g_out, c_out}), 64'(held_prb));
            end
            stall_prev = out_valid && !out_ready;
            held_res = {out_valid, sum, cout, ovf};
            held_prb = {p_out, g_out, c_out};
            if (out_valid && out_ready) begin
                if (sv.size() == 0) begin
                    check("unexpected_output", 64'(sum), 64'd0);
                    check("unexpected_output_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = sv.pop_front();
                    check("result_sum_cout_ovf", 64'({sum, cout, ovf}), 64'({e.sum, e.cout, e.ovf}));
                    check("probes_p_g_c", 64'({p_out, g_out, c_out}), 64'({e.p, e.g, e.c}));
                    if (e.chk_lat) check("latency", 64'(cyc - e.acc), 64'd4);
                end
            end
        end
    end

    // Single beat through one sweep instance; latency and result checked directly.
    task automatic sweep_beat(input int id, input logic [31:0] av, input logic [31:0] bv,
                              input logic ci, input logic sb, input logic [31:0] es,
                              input logic ec, input logic eo, input int en);
        int          lat;
        logic        v;
        logic [31:0] gs;
        logic [31:0] gc;
        logic        gco;
        logic        gof;
        lat = -1; gs = '0; gc = '0; gco = 1'b0; gof = 1'b0;
        sw_valid = 1'b1; sw_a = av; sw_b = bv; sw_cin = ci; sw_sub = sb;
        @(negedge clk);
        @(posedge clk);
        #1;
        sw_valid = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            case (id)
                0:       v = s0_ov;
                1:       v = s1_ov;
                default: v = s2_ov;
            endcase
            if (v && lat < 0) begin
                lat = j;
                case (id)
                    0:       begin gs = 32'(s0_sum); gco = s0_co; gof = s0_of; gc = 32'(s0_c); end
                    1:       begin gs = 32'(s1_sum); gco = s1_co; gof = s1_of; gc = 32'(s1_c); end
                    default: begin gs = s2_sum; gco = s2_co; gof = s2_of; gc = s2_c; end
                endcase
            end
        end
        check($sformatf("sweep%0d_latency", id), 64'(lat), 64'(en));
        check($sformatf("sweep%0d_sum_cout_ovf", id), 64'({gs, gco, gof}), 64'({es, ec, eo}));
        check($sformatf("sweep%0d_cmsb_eq_cout", id),
              64'(id == 2 ? gc[31] : gc[7]), 64'(ec));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum_cout_ovf", 64'({sum, cout, ovf}), 64'd0);
        check("reset_probes", 64'({p_out, g_out, c_out}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors, one at a time through an empty pipe.
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, mk(16'h0100, 1'b0, 1'b0, 16'h00FE, 16'h0001, 16'h00FF, 1'b1));
        drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b1));
        drain();
        send(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 16'h7FFE, 16'h8000, 16'h8000, 1'b1));
        drain();
        send(16'h0003, 16'h0005, 1'b1, 1'b1, mk(16'hFFFE, 1'b0, 1'b0, 16'hFFF9, 16'h0002, 16'h0003, 1'b1));
        drain();

        // Back-to-back stream under random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight: they must vanish.
        for (int i = 0; i < 3; i++) begin
            send(16'(16'h1111 * (i + 1)), 16'h0F0F, 1'b0, 1'b0, model(16'(16'h1111 * (i + 1)), 16'h0F0F, 1'b0, 1'b0));
        end
        rst = 1'b1;
        sv.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum_cout_ovf", 64'({sum, cout, ovf}), 64'd0);
        check("midrst_probes", 64'({p_out, g_out, c_out}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_idle_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0, 16'h5115, 16'h0220, 16'h0220, 1'b1));
        drain();

        // Parameter sweep: latency equals the segment count.
        sweep_beat(0, 32'h0000_007F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0080, 1'b0, 1'b1, 1);
        sweep_beat(1, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_00F0, 1'b0, 1'b0, 4);
        sweep_beat(1, 32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_007F, 1'b1, 1'b1, 4);
        sweep_beat(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 8);
        check("sweep2_carry_vector", 64'(s2_c), 64'hFFFF_FFFF);
        sweep_beat(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
